shf_issue_ctl: RTL and testbench
================================

// Module: shf_issue_ctl
// PURPOSE
//  Sequencer-side initiator for the shifter unit. Accepts one decoded shift instruction
//  (class, Rn, Rx, Ry), reads operands from the register file, and drives the shifter's
//  ps_shf_en/ps_shf_cls/xb_dtx/xb_dty. It captures shf_xb_dt and the SV/SZ flags one cycle
//  after the shifter latches, then writes Rn back and updates status flags. Sits between
//  the instruction decoder / register file and the shifter.
// PARAMETERS
//  DATASIZE  16  operand/result width; must match the shifter
//  RFADDR    4   register-file address width (16 registers)
// PORTS
//  clk            in   1         clock, all state on posedge
//  reset          in   1         asynchronous, active-low; all regs cleared while low
//  ps_si_vld      in   1         instruction valid
//  si_ps_rdy      out  1         instruction accepted on the edge where vld & rdy
//  ps_si_cls      in   2         00 arith shift, 01 rotate, 10 lead-zero count, 11 lead-one count
//  ps_si_rn       in   RFADDR    destination register
//  ps_si_rx       in   RFADDR    operand-X register
//  ps_si_ry       in   RFADDR    operand-Y register (shift/rotate amount)
//  ps_si_flush    in   1         abort the in-flight instruction (no write-back)
//  ps_si_clr      in   1         clear sticky overflow si_ps_svs
//  si_rf_rxa      out  RFADDR    RF read address X (= ps_si_rx, combinational)
//  si_rf_rya      out  RFADDR    RF read address Y (= ps_si_ry, combinational)
//  rf_si_dtx      in   DATASIZE  RF read data X (combinational read)
//  rf_si_dty      in   DATASIZE  RF read data Y
//  ps_shf_en      out  1         shifter enable, registered
//  ps_shf_cls     out  2         shifter class, registered
//  xb_dtx         out  DATASIZE  shifter operand X, registered
//  xb_dty         out  DATASIZE  shifter operand Y, registered
//  shf_xb_dt      in   DATASIZE  shifter result
//  shf_ps_sv      in   1         shifter overflow flag
//  shf_ps_sz      in   1         shifter zero flag
//  si_rf_we       out  1         RF write enable, one-cycle pulse
//  si_rf_wa       out  RFADDR    RF write address
//  si_rf_wd       out  DATASIZE  RF write data
//  si_ps_sv       out  1         last committed SV flag
//  si_ps_sz       out  1         last committed SZ flag
//  si_ps_svs      out  1         sticky overflow
// BEHAVIOUR
//  - Reset: state=IDLE; every output register is 0 (ps_shf_en, ps_shf_cls, xb_dtx/dty,
//    si_rf_we/wa/wd, si_ps_sv/sz/svs). si_ps_rdy=1 on the first cycle after release.
//  - FSM: IDLE -> SEND -> RES -> WB -> IDLE. si_ps_rdy=1 in IDLE and WB only.
//  - Accept (IDLE or WB, vld & rdy): on that edge, register rn/cls internally and load
//    xb_dtx/xb_dty from the forwarded RF data; set ps_shf_cls=ps_si_cls, ps_shf_en<=1; go SEND.
//  - SEND: ps_shf_en=1 for exactly this cycle; the shifter latches operands at its end; go RES.
//  - RES: shifter output is valid; register shf_xb_dt->si_rf_wd, rn->si_rf_wa,
//    sv/sz->pending; set si_rf_we<=1; go WB.
//  - WB: si_rf_we=1 for one cycle; si_ps_sv/sz take the pending flags at the end of WB.
//    svs sets if sv=1. Without a new accept, go IDLE.
//  - Latency: accept edge = cycle 0; SEND = 1; RES = 2; WB = 3. Throughput: 1 instruction
//    per 3 cycles (accept allowed in WB).
//  - Forwarding: an accept during WB whose rx (or ry) equals si_rf_wa uses si_rf_wd instead
//    of rf_si_dtx (or dty). Check both ports independently.
//  - Classes 1x: xb_dty is still loaded; the shifter ignores it.
//  - Flush: in SEND or RES -> go IDLE next edge, ps_shf_en<=0, no si_rf_we, flags unchanged.
//    Flush in WB or IDLE is ignored. Flush together with an accept in WB: the accept proceeds.
//  - Sticky: ps_si_clr clears svs. A set and a clear on the same edge -> set wins.
//  - Reset asserted mid-operation aborts immediately: no write-back, all outputs to 0.
// STRUCTURE
//  - Shared include shf_defs.vh: class codes SHF_ASH=2'b00, SHF_ROT=2'b01, SHF_LZ=2'b10,
//    SHF_LO=2'b11; state codes S_IDLE/S_SEND/S_RES/S_WB (2 bits).
//  - One sub-module, shf_fwd_mux: RF-vs-writeback operand select for X and Y.
//  - Integrated bench instantiates this block together with the shifter and a 16x16 RF model.
// TESTING
//  - R2=0xF000, R3=0xFFFC, cls 00, Rn=R5 -> cycle 3: we=1, wa=5, wd=0xFF00; sv=0, sz=0.
//  - R2=0xC000, R3=0x0002, cls 01 -> wd=0x0003, sv=0, sz=0.
//  - R2=0x0000, cls 10 -> wd=0x0010, sv=1, sz=0, svs=1. Then clr -> svs=0.
//    Clr on the same edge as a new sv=1 -> svs stays 1.
//  - A: R4 = R1(0x0001) by R6(0x0003), cls 00 -> 0x0008. B (cls 11, rx=R4) accepted during
//    A's WB -> B uses 0x0008 forwarded; B wd=0x0000, sz=1, sv=0. Accept-to-accept is 3 cycles.
//  - Flush asserted in RES -> no si_rf_we pulse, sv/sz/svs unchanged, rdy=1 next cycle.
//  - reset low during SEND -> every output 0 at once. After release, a clean instruction
//    completes normally.

Source files
------------

// File: rtl/shf_issue_ctl_pkg.sv
// Shared definitions for the shifter issue controller.
//   shf_cls_e   : shifter operation classes (arith shift, rotate, lead-zero, lead-one)
//   S_*         : issue FSM state encodings (2 bits)
//   issue_ready : states in which a new instruction may be accepted
package shf_issue_ctl_pkg;

  typedef enum logic [1:0] {
    SHF_ASH = 2'b00,
    SHF_ROT = 2'b01,
    SHF_LZ  = 2'b10,
    SHF_LO  = 2'b11
  } shf_cls_e;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_SEND = 2'b01;
  localparam logic [1:0] S_RES  = 2'b10;
  localparam logic [1:0] S_WB   = 2'b11;

  // Accepting in WB is what gives one instruction every three cycles.
  function automatic logic issue_ready(input logic [1:0] st);
    return (st == S_IDLE) || (st == S_WB);
  endfunction

endpackage

// File: rtl/shf_issue_ctl_if.sv
// Issue-controller <-> shifter bus.
//   master (issue controller): drives ps_shf_en, ps_shf_cls, xb_dtx, xb_dty;
//                              receives shf_xb_dt, shf_ps_sv, shf_ps_sz
//   slave  (shifter)         : the reverse
interface shf_issue_ctl_if #(
  parameter int DATASIZE = 16
) ();
  logic                ps_shf_en;
  logic [1:0]          ps_shf_cls;
  logic [DATASIZE-1:0] xb_dtx;
  logic [DATASIZE-1:0] xb_dty;
  logic [DATASIZE-1:0] shf_xb_dt;
  logic                shf_ps_sv;
  logic                shf_ps_sz;

  modport master (
    output ps_shf_en, ps_shf_cls, xb_dtx, xb_dty,
    input  shf_xb_dt, shf_ps_sv, shf_ps_sz
  );

  modport slave (
    input  ps_shf_en, ps_shf_cls, xb_dtx, xb_dty,
    output shf_xb_dt, shf_ps_sv, shf_ps_sz
  );
endinterface

// File: rtl/shf_fwd_mux.sv
// Operand select between register-file read data and the result being written
// back this cycle. The RF write lands at the end of WB, so an instruction
// accepted in WB would otherwise read the stale value.
//   fwd_en        : write-back result is live (controller is in WB)
//   rxa / rya     : operand read addresses
//   wa / wd       : write-back address / data
//   rf_dtx/rf_dty : RF read data
//   opx / opy     : selected operands (X and Y compared independently)
module shf_fwd_mux #(
  parameter int DATASIZE = 16,
  parameter int RFADDR   = 4
) (
  input  logic                fwd_en,
  input  logic [RFADDR-1:0]   rxa,
  input  logic [RFADDR-1:0]   rya,
  input  logic [RFADDR-1:0]   wa,
  input  logic [DATASIZE-1:0] wd,
  input  logic [DATASIZE-1:0] rf_dtx,
  input  logic [DATASIZE-1:0] rf_dty,
  output logic [DATASIZE-1:0] opx,
  output logic [DATASIZE-1:0] opy
);

  assign opx = (fwd_en && (rxa == wa)) ? wd : rf_dtx;
  assign opy = (fwd_en && (rya == wa)) ? wd : rf_dty;

endmodule

// File: rtl/shf_issue_ctl.sv
// Shifter issue controller: accepts one decoded shift instruction, reads its
// operands, drives the shifter for one cycle, captures the result and writes
// it back to the register file while updating the SV/SZ/sticky flags.
//
// Ports:
//   clk, reset (async, active-low)
//   ps_si_vld / si_ps_rdy         : instruction handshake
//   ps_si_cls/rn/rx/ry            : decoded instruction fields
//   ps_si_flush                   : abort in-flight instruction (SEND/RES only)
//   ps_si_clr                     : clear sticky overflow
//   si_rf_rxa/rya, rf_si_dtx/dty  : RF read port (combinational)
//   shf                           : shifter bus (master side)
//   si_rf_we/wa/wd                : RF write port
//   si_ps_sv/sz/svs               : committed flags and sticky overflow
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for an instruction, rdy=1
// S_SEND | ps_shf_en high, shifter latches operands at end of cycle
// S_RES  | shifter result valid, captured into write-back registers
// S_WB   | si_rf_we pulse, flags commit at end; next instruction may issue
module shf_issue_ctl
  import shf_issue_ctl_pkg::*;
#(
  parameter int DATASIZE = 16,
  parameter int RFADDR   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_si_vld,
  output logic                si_ps_rdy,
  input  logic [1:0]          ps_si_cls,
  input  logic [RFADDR-1:0]   ps_si_rn,
  input  logic [RFADDR-1:0]   ps_si_rx,
  input  logic [RFADDR-1:0]   ps_si_ry,
  input  logic                ps_si_flush,
  input  logic                ps_si_clr,
  output logic [RFADDR-1:0]   si_rf_rxa,
  output logic [RFADDR-1:0]   si_rf_rya,
  input  logic [DATASIZE-1:0] rf_si_dtx,
  input  logic [DATASIZE-1:0] rf_si_dty,
  shf_issue_ctl_if.master     shf,
  output logic                si_rf_we,
  output logic [RFADDR-1:0]   si_rf_wa,
  output logic [DATASIZE-1:0] si_rf_wd,
  output logic                si_ps_sv,
  output logic                si_ps_sz,
  output logic                si_ps_svs
);

  logic [1:0]          state;
  logic [RFADDR-1:0]   rn_q;
  logic                sv_pend;
  logic                sz_pend;
  logic                accept;
  logic                flush_act;
  logic [DATASIZE-1:0] opx;
  logic [DATASIZE-1:0] opy;

  assign si_rf_rxa = ps_si_rx;
  assign si_rf_rya = ps_si_ry;
  assign si_ps_rdy = issue_ready(state);
  assign accept    = ps_si_vld && si_ps_rdy;
  // Flush only matters while the instruction is still in the shifter.
  assign flush_act = ps_si_flush && ((state == S_SEND) || (state == S_RES));

  shf_fwd_mux #(
    .DATASIZE (DATASIZE),
    .RFADDR   (RFADDR)
  ) u_fwd (
    .fwd_en (state == S_WB),
    .rxa    (ps_si_rx),
    .rya    (ps_si_ry),
    .wa     (si_rf_wa),
    .wd     (si_rf_wd),
    .rf_dtx (rf_si_dtx),
    .rf_dty (rf_si_dty),
    .opx    (opx),
    .opy    (opy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      rn_q           <= '0;
      sv_pend        <= 1'b0;
      sz_pend        <= 1'b0;
      shf.ps_shf_en  <= 1'b0;
      shf.ps_shf_cls <= 2'b00;
      shf.xb_dtx     <= '0;
      shf.xb_dty     <= '0;
      si_rf_we       <= 1'b0;
      si_rf_wa       <= '0;
      si_rf_wd       <= '0;
      si_ps_sv       <= 1'b0;
      si_ps_sz       <= 1'b0;
    end else begin
      shf.ps_shf_en <= 1'b0;
      si_rf_we      <= 1'b0;

      // accept is only possible in IDLE or WB; Y is loaded for every class,
      // lead-count classes simply ignore it in the shifter.
      if (accept) begin
        rn_q           <= ps_si_rn;
        shf.ps_shf_cls <= ps_si_cls;
        shf.xb_dtx     <= opx;
        shf.xb_dty     <= opy;
        shf.ps_shf_en  <= 1'b1;
      end

      case (state)
        S_IDLE: state <= accept ? S_SEND : S_IDLE;
        S_SEND: state <= flush_act ? S_IDLE : S_RES;
        S_RES: begin
          if (flush_act) begin
            state <= S_IDLE;
          end else begin
            si_rf_wd <= shf.shf_xb_dt;
            si_rf_wa <= rn_q;
            sv_pend  <= shf.shf_ps_sv;
            sz_pend  <= shf.shf_ps_sz;
            si_rf_we <= 1'b1;
            state    <= S_WB;
          end
        end
        S_WB: begin
          si_ps_sv <= sv_pend;
          si_ps_sz <= sz_pend;
          state    <= accept ? S_SEND : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A new overflow committing on the same edge as a clear keeps svs set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      si_ps_svs <= 1'b0;
    end else if ((state == S_WB) && sv_pend) begin
      si_ps_svs <= 1'b1;
    end else if (ps_si_clr) begin
      si_ps_svs <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shf_issue_ctl.sv
module tb_shf_issue_ctl;

  localparam logic [1:0] C_ASH = 2'b00;
  localparam logic [1:0] C_ROT = 2'b01;
  localparam logic [1:0] C_LZ  = 2'b10;
  localparam logic [1:0] C_LO  = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps_si_vld = 1'b0;
  logic        si_ps_rdy;
  logic [1:0]  ps_si_cls = 2'b00;
  logic [3:0]  ps_si_rn = '0;
  logic [3:0]  ps_si_rx = '0;
  logic [3:0]  ps_si_ry = '0;
  logic        ps_si_flush = 1'b0;
  logic        ps_si_clr = 1'b0;
  logic [3:0]  si_rf_rxa, si_rf_rya;
  logic [15:0] rf_si_dtx, rf_si_dty;
  logic        si_rf_we;
  logic [3:0]  si_rf_wa;
  logic [15:0] si_rf_wd;
  logic        si_ps_sv, si_ps_sz, si_ps_svs;

  logic        tb_we = 1'b0;
  logic [3:0]  tb_wa = '0;
  logic [15:0] tb_wd = '0;
  logic [15:0] rf [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shf_issue_ctl_if #(.DATASIZE(16)) shf_bus ();

  shf_issue_ctl #(.DATASIZE(16), .RFADDR(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps_si_vld   (ps_si_vld),
    .si_ps_rdy   (si_ps_rdy),
    .ps_si_cls   (ps_si_cls),
    .ps_si_rn    (ps_si_rn),
    .ps_si_rx    (ps_si_rx),
    .ps_si_ry    (ps_si_ry),
    .ps_si_flush (ps_si_flush),
    .ps_si_clr   (ps_si_clr),
    .si_rf_rxa   (si_rf_rxa),
    .si_rf_rya   (si_rf_rya),
    .rf_si_dtx   (rf_si_dtx),
    .rf_si_dty   (rf_si_dty),
    .shf         (shf_bus),
    .si_rf_we    (si_rf_we),
    .si_rf_wa    (si_rf_wa),
    .si_rf_wd    (si_rf_wd),
    .si_ps_sv    (si_ps_sv),
    .si_ps_sz    (si_ps_sz),
    .si_ps_svs   (si_ps_svs)
  );

  // 16x16 register file: combinational read, write on posedge
  assign rf_si_dtx = rf[si_rf_rxa];
  assign rf_si_dty = rf[si_rf_rya];
  always @(posedge clk) begin
    if (tb_we) rf[tb_wa] <= tb_wd;
    else if (si_rf_we) rf[si_rf_wa] <= si_rf_wd;
  end

  // Shifter: latches result and flags on the edge ending an enable cycle.
  // Returns {sv, result}.
  function automatic logic [16:0] shf_calc(input logic [1:0] cls, input logic [15:0] x,
                                           input logic [15:0] y);
    logic [15:0] res;
    logic        sv;
    logic [31:0] w;
    int          n;
    int          cnt;
    logic        found;
    res = '0; sv = 1'b0; w = '0; cnt = 0; found = 1'b0;
    case (cls)
      C_ASH: begin
        if (y[15]) begin
          n = int'(-$signed(y));
          if (n > 15) n = 15;
          res = 16'($signed(x) >>> n);
        end else begin
          n = (y > 16'd16) ? 16 : int'(y);
          w = {{16{x[15]}}, x} << n;
          res = w[15:0];
          sv = (w[31:16] != {16{w[15]}});
        end
      end
      C_ROT: begin
        w = {x, x} << y[3:0];
        res = w[31:16];
      end
      default: begin
        for (int i = 15; i >= 0; i--) begin
          if (!found) begin
            if (x[i] == cls[0]) cnt++;
            else found = 1'b1;
          end
        end
        res = 16'(cnt);
        sv = (cnt == 16);
      end
    endcase
    return {sv, res};
  endfunction

  always @(posedge clk) begin
    if (shf_bus.ps_shf_en) begin
      {shf_bus.shf_ps_sv, shf_bus.shf_xb_dt} <=
        shf_calc(shf_bus.ps_shf_cls, shf_bus.xb_dtx, shf_bus.xb_dty);
      shf_bus.shf_ps_sz <= (shf_calc(shf_bus.ps_shf_cls, shf_bus.xb_dtx, shf_bus.xb_dty) & 17'h0FFFF) == 17'd0;
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic rf_load(input logic [3:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic drive(input logic [1:0] cls, input logic [3:0] rn, input logic [3:0] rx,
                       input logic [3:0] ry);
    ps_si_vld = 1'b1; ps_si_cls = cls; ps_si_rn = rn; ps_si_rx = rx; ps_si_ry = ry;
  endtask

  task automatic test_reset;
    tick(); tick();
    checks++;
    if ({shf_bus.ps_shf_en, shf_bus.ps_shf_cls, si_rf_we, si_ps_sv, si_ps_sz, si_ps_svs} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl_bits: got %b expected 0",
        {shf_bus.ps_shf_en, shf_bus.ps_shf_cls, si_rf_we, si_ps_sv, si_ps_sz, si_ps_svs});
    end
    checks++;
    if ({shf_bus.xb_dtx, shf_bus.xb_dty, si_rf_wd, si_rf_wa} !== 52'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0",
        {shf_bus.xb_dtx, shf_bus.xb_dty, si_rf_wd, si_rf_wa});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (si_ps_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_rdy: got %b expected 1", si_ps_rdy);
    end
  endtask

  task automatic test_ash;
    rf_load(4'd2, 16'hF000);
    rf_load(4'd3, 16'hFFFC);
    drive(C_ASH, 4'd5, 4'd2, 4'd3);
    tick(); ps_si_vld = 1'b0;
    checks++;
    if ({shf_bus.ps_shf_en, shf_bus.ps_shf_cls, si_ps_rdy} !== 4'b1000) begin
      errors++; $display("FAIL ash_send_ctl: got %b expected 1000",
        {shf_bus.ps_shf_en, shf_bus.ps_shf_cls, si_ps_rdy});
    end
    checks++;
    if ({shf_bus.xb_dtx, shf_bus.xb_dty} !== 32'hF000FFFC) begin
      errors++; $display("FAIL ash_operands: got %h expected F000FFFC",
        {shf_bus.xb_dtx, shf_bus.xb_dty});
    end
    tick();
    checks++;
    if ({shf_bus.ps_shf_en, si_rf_we, si_ps_rdy} !== 3'b000) begin
      errors++; $display("FAIL ash_res_ctl: got %b expected 000",
        {shf_bus.ps_shf_en, si_rf_we, si_ps_rdy});
    end
    tick();
    checks++;
    if ({si_rf_we, si_rf_wa, si_rf_wd, si_ps_rdy} !== {1'b1, 4'd5, 16'hFF00, 1'b1}) begin
      errors++; $display("FAIL ash_wb: got we=%b wa=%0d wd=%h rdy=%b expected we=1 wa=5 wd=ff00 rdy=1",
        si_rf_we, si_rf_wa, si_rf_wd, si_ps_rdy);
    end
    tick();
    checks++;
    if ({si_rf_we, si_ps_sv, si_ps_sz, rf[5]} !== {3'b000, 16'hFF00}) begin
      errors++; $display("FAIL ash_done: got we=%b sv=%b sz=%b r5=%h expected 0 0 0 ff00",
        si_rf_we, si_ps_sv, si_ps_sz, rf[5]);
    end
  endtask

  task automatic test_rot;
    rf_load(4'd2, 16'hC000);
    rf_load(4'd3, 16'h0002);
    drive(C_ROT, 4'd7, 4'd2, 4'd3);
    tick(); ps_si_vld = 1'b0;
    tick(); tick();
    checks++;
    if ({si_rf_we, si_rf_wa, si_rf_wd} !== {1'b1, 4'd7, 16'h0003}) begin
      errors++; $display("FAIL rot_wb: got we=%b wa=%0d wd=%h expected 1 7 0003",
        si_rf_we, si_rf_wa, si_rf_wd);
    end
    tick();
    checks++;
    if ({si_ps_sv, si_ps_sz} !== 2'b00) begin
      errors++; $display("FAIL rot_flags: got %b expected 00", {si_ps_sv, si_ps_sz});
    end
  endtask

  task automatic test_lz_sticky;
    rf_load(4'd8, 16'h0000);
    drive(C_LZ, 4'd9, 4'd8, 4'd3);
    tick(); ps_si_vld = 1'b0;
    tick(); tick();
    checks++;
    if ({si_rf_we, si_rf_wa, si_rf_wd} !== {1'b1, 4'd9, 16'h0010}) begin
      errors++; $display("FAIL lz_wb: got we=%b wa=%0d wd=%h expected 1 9 0010",
        si_rf_we, si_rf_wa, si_rf_wd);
    end
    tick();
    checks++;
    if ({si_ps_sv, si_ps_sz, si_ps_svs} !== 3'b101) begin
      errors++; $display("FAIL lz_flags: got sv/sz/svs=%b expected 101", {si_ps_sv, si_ps_sz, si_ps_svs});
    end
    ps_si_clr = 1'b1;
    tick();
    ps_si_clr = 1'b0;
    checks++;
    if (si_ps_svs !== 1'b0) begin
      errors++; $display("FAIL svs_clear: got %b expected 0", si_ps_svs);
    end
    ps_si_clr = 1'b1;
    drive(C_LZ, 4'd9, 4'd8, 4'd3);
    tick(); ps_si_vld = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (si_ps_svs !== 1'b1) begin
      errors++; $display("FAIL svs_set_wins: got %b expected 1", si_ps_svs);
    end
    tick();
    ps_si_clr = 1'b0;
    checks++;
    if (si_ps_svs !== 1'b0) begin
      errors++; $display("FAIL svs_clear_after: got %b expected 0", si_ps_svs);
    end
  endtask

  task automatic test_flush;
    rf_load(4'd12, 16'h1234);
    rf_load(4'd3, 16'h0002);
    // flush in RES: ASH 0 by 2 would commit sz=1, sv=0
    drive(C_ASH, 4'd12, 4'd8, 4'd3);
    tick(); ps_si_vld = 1'b0;
    tick(); ps_si_flush = 1'b1;
    tick(); ps_si_flush = 1'b0;
    checks++;
    if ({si_rf_we, si_ps_rdy, shf_bus.ps_shf_en} !== 3'b010) begin
      errors++; $display("FAIL flush_res_next: got we/rdy/en=%b expected 010",
        {si_rf_we, si_ps_rdy, shf_bus.ps_shf_en});
    end
    tick();
    checks++;
    if ({si_rf_we, si_ps_sv, si_ps_sz, si_ps_svs, rf[12]} !== {4'b0100, 16'h1234}) begin
      errors++; $display("FAIL flush_res_state: got we=%b sv=%b sz=%b svs=%b r12=%h expected 0 1 0 0 1234",
        si_rf_we, si_ps_sv, si_ps_sz, si_ps_svs, rf[12]);
    end
    // flush in SEND
    drive(C_ASH, 4'd12, 4'd8, 4'd3);
    tick(); ps_si_vld = 1'b0; ps_si_flush = 1'b1;
    tick(); ps_si_flush = 1'b0;
    checks++;
    if ({si_ps_rdy, shf_bus.ps_shf_en, si_rf_we} !== 3'b100) begin
      errors++; $display("FAIL flush_send_next: got rdy/en/we=%b expected 100",
        {si_ps_rdy, shf_bus.ps_shf_en, si_rf_we});
    end
    tick(); tick();
    checks++;
    if ({si_rf_we, si_ps_sz, rf[12]} !== {2'b00, 16'h1234}) begin
      errors++; $display("FAIL flush_send_state: got we=%b sz=%b r12=%h expected 0 0 1234",
        si_rf_we, si_ps_sz, rf[12]);
    end
  endtask

  task automatic test_back_to_back;
    rf_load(4'd1, 16'h0001);
    rf_load(4'd6, 16'h0003);
    // A: R4 = R1 << R6
    drive(C_ASH, 4'd4, 4'd1, 4'd6);
    tick(); ps_si_vld = 1'b0;
    tick(); tick();
    checks++;
    if ({si_rf_we, si_rf_wa, si_rf_wd, si_ps_rdy} !== {1'b1, 4'd4, 16'h0008, 1'b1}) begin
      errors++; $display("FAIL b2b_a_wb: got we=%b wa=%0d wd=%h rdy=%b expected 1 4 0008 1",
        si_rf_we, si_rf_wa, si_rf_wd, si_ps_rdy);
    end
    // B accepted in A's WB: X forwarded, Y from RF
    drive(C_LO, 4'd10, 4'd4, 4'd6);
    tick(); ps_si_vld = 1'b0;
    checks++;
    if ({shf_bus.ps_shf_en, shf_bus.ps_shf_cls, shf_bus.xb_dtx, shf_bus.xb_dty} !==
        {1'b1, 2'b11, 16'h0008, 16'h0003}) begin
      errors++; $display("FAIL b2b_b_send: got en=%b cls=%b x=%h y=%h expected 1 11 0008 0003",
        shf_bus.ps_shf_en, shf_bus.ps_shf_cls, shf_bus.xb_dtx, shf_bus.xb_dty);
    end
    checks++;
    if ({si_ps_sv, si_ps_sz, rf[4]} !== {2'b00, 16'h0008}) begin
      errors++; $display("FAIL b2b_a_commit: got sv=%b sz=%b r4=%h expected 0 0 0008",
        si_ps_sv, si_ps_sz, rf[4]);
    end
    tick(); tick();
    checks++;
    if ({si_rf_we, si_rf_wa, si_rf_wd, si_ps_rdy} !== {1'b1, 4'd10, 16'h0000, 1'b1}) begin
      errors++; $display("FAIL b2b_b_wb: got we=%b wa=%0d wd=%h rdy=%b expected 1 10 0000 1",
        si_rf_we, si_rf_wa, si_rf_wd, si_ps_rdy);
    end
    // C accepted in B's WB: Y forwarded only
    drive(C_ASH, 4'd11, 4'd1, 4'd10);
    tick(); ps_si_vld = 1'b0;
    checks++;
    if ({shf_bus.xb_dtx, shf_bus.xb_dty} !== 32'h0001_0000) begin
      errors++; $display("FAIL b2b_c_operands: got x=%h y=%h expected 0001 0000",
        shf_bus.xb_dtx, shf_bus.xb_dty);
    end
    checks++;
    if ({si_ps_sv, si_ps_sz} !== 2'b01) begin
      errors++; $display("FAIL b2b_b_flags: got sv/sz=%b expected 01", {si_ps_sv, si_ps_sz});
    end
    tick(); tick();
    checks++;
    if ({si_rf_we, si_rf_wa, si_rf_wd} !== {1'b1, 4'd11, 16'h0001}) begin
      errors++; $display("FAIL b2b_c_wb: got we=%b wa=%0d wd=%h expected 1 11 0001",
        si_rf_we, si_rf_wa, si_rf_wd);
    end
    tick();
    checks++;
    if ({si_ps_sz, si_rf_we} !== 2'b00) begin
      errors++; $display("FAIL b2b_c_done: got sz/we=%b expected 00", {si_ps_sz, si_rf_we});
    end
  endtask

  task automatic test_reset_mid;
    drive(C_LZ, 4'd13, 4'd8, 4'd3);
    tick(); ps_si_vld = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (si_ps_svs !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre_svs: got %b expected 1", si_ps_svs);
    end
    rf_load(4'd14, 16'h5A5A);
    drive(C_ROT, 4'd14, 4'd2, 4'd3);
    tick(); ps_si_vld = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({shf_bus.ps_shf_en, shf_bus.ps_shf_cls, si_rf_we, si_ps_sv, si_ps_sz, si_ps_svs,
         shf_bus.xb_dtx, shf_bus.xb_dty, si_rf_wa, si_rf_wd} !== 59'd0) begin
      errors++; $display("FAIL rstmid_outputs: got en=%b cls=%b we=%b sv=%b sz=%b svs=%b x=%h y=%h wa=%h wd=%h expected all 0",
        shf_bus.ps_shf_en, shf_bus.ps_shf_cls, si_rf_we, si_ps_sv, si_ps_sz, si_ps_svs,
        shf_bus.xb_dtx, shf_bus.xb_dty, si_rf_wa, si_rf_wd);
    end
    checks++;
    if (si_ps_rdy !== 1'b1) begin
      errors++; $display("FAIL rstmid_rdy: got %b expected 1", si_ps_rdy);
    end
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({si_rf_we, rf[14]} !== {1'b0, 16'h5A5A}) begin
      errors++; $display("FAIL rstmid_no_wb: got we=%b r14=%h expected 0 5a5a", si_rf_we, rf[14]);
    end
    drive(C_ROT, 4'd15, 4'd2, 4'd3);
    tick(); ps_si_vld = 1'b0;
    tick(); tick();
    checks++;
    if ({si_rf_we, si_rf_wa, si_rf_wd} !== {1'b1, 4'd15, 16'h0003}) begin
      errors++; $display("FAIL rstmid_clean: got we=%b wa=%0d wd=%h expected 1 15 0003",
        si_rf_we, si_rf_wa, si_rf_wd);
    end
    tick();
    checks++;
    if ({si_ps_sv, si_ps_sz, rf[15]} !== {2'b00, 16'h0003}) begin
      errors++; $display("FAIL rstmid_clean_done: got sv=%b sz=%b r15=%h expected 0 0 0003",
        si_ps_sv, si_ps_sz, rf[15]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    test_reset();
    test_ash();
    test_rot();
    test_lz_sticky();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
